button_irq_controller: RTL
==========================

Name: button_irq_controller

Overview:
- Memory-mapped controller for the board pushbuttons, exposed to the HPS as a lightweight-bridge slave.
- Per button, in order: 2-flop synchroniser, debounce filter, edge detector.
- Edge events latch into a sticky capture register; a masked level interrupt drives the HPS IRQ line.
- Inputs are active-high; the top level inverts KEY before connecting it here.

Parameters:
- NUM_BUTTONS, 4, number of button inputs (1..16).
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles before a level change is accepted (20 ms at 50 MHz); minimum 2.
- REPEAT_CYCLES, 12500000, auto-repeat period while held; used only with the optional feature.

Ports:
- clk  input  1  system clock, 50 MHz domain.
- reset_n  input  1  asynchronous active-low reset.
- buttons  input  NUM_BUTTONS  raw active-high button levels, asynchronous to clk.
- avs_address  input  2  word address.
- avs_read  input  1  read strobe.
- avs_write  input  1  write strobe.
- avs_writedata  input  32  write data.
- avs_readdata  output  32  read data, valid the cycle after avs_read.
- irq  output  1  level interrupt to the HPS.

Behaviour:
- Reset: all sync flops, stable levels, counters, capture, mask and config are 0; avs_readdata=0; irq=0.
- Synchroniser: two flops per bit. Latency from pin to sync output is 2 cycles.
- Debounce FSM, one per button:
  - IDLE: sync==stable; counter held at 0.
  - COUNT: sync!=stable; counter increments each cycle. If sync returns to stable, counter goes to 0 and the FSM returns to IDLE.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable flips, the counter clears, and the FSM returns to IDLE.
  - Counter width is $clog2(DEBOUNCE_CYCLES). No wrap is possible.
- Edge event: a one-cycle pulse on the cycle stable flips.
  - CONFIG.both=0: only 0->1 (press) generates an event.
  - CONFIG.both=1: both directions generate events.
- Register map (all accesses are full 32-bit; unused bits read 0; writes to RO registers are ignored):
  - 0 DATA, RO: stable levels [NUM_BUTTONS-1:0].
  - 1 MASK, RW: irq enable per button.
  - 2 EDGE, RW1C: sticky capture. An event sets its bit; writing 1 clears it.
  - 3 CONFIG, RW: bit0=both, bit1=global irq enable.
- Read latency is exactly 1 cycle. avs_readdata holds its value until the next read.
- A simultaneous read and write to the same address returns the pre-write value.
- Same-cycle event and W1C on the same bit: the set wins, so no event is lost.
- irq is registered: irq <= CONFIG[1] & |(EDGE & MASK). It asserts 1 cycle after the capture bit sets and deasserts 1 cycle after the clear.
- reset_n asserted mid-debounce: the count is abandoned. After release, a held button needs the full 2+DEBOUNCE_CYCLES cycles to register.
- Glitches shorter than DEBOUNCE_CYCLES never change DATA or EDGE.

Optional Feature:
- Macro: BUTTON_IRQ_AUTOREPEAT_EN.
- Defined:
  - Each button has a repeat counter that runs while stable==1 and clears when stable==0.
  - Each time it reaches REPEAT_CYCLES-1, a press event is generated and the counter restarts.
  - CONFIG bit2 enables auto-repeat and resets to 0.
- Undefined:
  - No repeat logic is built.
  - CONFIG bit2 reads 0 and ignores writes.

Decomposition:
- Package button_irq_pkg:
  - Register address constants ADDR_DATA/ADDR_MASK/ADDR_EDGE/ADDR_CONFIG.
  - CONFIG bit indices CFG_BOTH/CFG_IRQ_EN/CFG_REPEAT.
  - Debounce state encoding (IDLE, COUNT).
- Sub-module button_debouncer:
  - Contains the sync, FSM and edge detector for one button.
  - Outputs stable, rise_pulse and fall_pulse.
  - Instantiated NUM_BUTTONS times in a generate loop.
  - The register file and irq logic stay in the top module.

Test Plan (bench uses DEBOUNCE_CYCLES=16, REPEAT_CYCLES=64):
- Reset: hold reset_n=0 with buttons=4'hF, then release. DATA reads 0, irq=0. DATA=4'hF appears exactly 2+16 cycles after release.
- Bounce rejection: toggle buttons[0] high for 10 cycles, low for 3, then high steady. DATA[0]=1 only 18 cycles after the final rise. EDGE=4'h1, with a single event.
- IRQ path:
  - MASK=4'h2, CONFIG=2'b10, press button 1: irq=1 one cycle after EDGE[1] sets.
  - Write EDGE=4'h2: irq=0 two cycles after the write.
  - Pressing button 0 (unmasked) keeps irq=0.
- W1C race: time a write EDGE=4'h1 on the same cycle as a button 0 press event. EDGE[0] reads 1 afterward.
- Both-edges mode:
  - CONFIG=2'b11, press and release button 3, clearing EDGE between the two. EDGE[3] sets on each transition.
  - With CONFIG=2'b10, the release sets nothing.
- Auto-repeat (BUTTON_IRQ_AUTOREPEAT_EN defined):
  - CONFIG bit2=1, hold button 2 for 200 cycles after debounce. Repeat events occur at 64, 128 and 192 cycles.
  - Clear EDGE after each event and count three re-sets.
  - Without the macro, CONFIG reads bit2=0.

Source files
------------

// File: rtl/button_irq_pkg.sv
// Shared constants for the pushbutton interrupt controller: register map,
// CONFIG bit positions and the debounce state encoding.
package button_irq_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_EDGE   = 2'd2;
  localparam logic [1:0] ADDR_CONFIG = 2'd3;

  localparam int CFG_BOTH   = 0;
  localparam int CFG_IRQ_EN = 1;
  localparam int CFG_REPEAT = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } db_state_t;

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser, debounce FSM and edge pulses.
//   state | meaning
//   IDLE  | synchronised level equals stable level, counter held at 0
//   COUNT | level differs from stable, counting consecutive differing cycles
module button_debouncer
  import button_irq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button,
  output logic stable,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync0;
  logic          sync1;
  logic [CW-1:0] cnt;
  db_state_t     state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0      <= 1'b0;
      sync1      <= 1'b0;
      stable     <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      cnt        <= '0;
      state      <= IDLE;
    end else begin
      sync0      <= button;
      sync1      <= sync0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        IDLE: begin
          // The first differing cycle already counts as one.
          if (sync1 != stable) begin
            cnt   <= CW'(1);
            state <= COUNT;
          end else begin
            cnt <= '0;
          end
        end
        COUNT: begin
          if (sync1 == stable) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable     <= sync1;
            rise_pulse <= sync1;
            fall_pulse <= ~sync1;
            cnt        <= '0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_irq_controller.sv
// Pushbutton controller slave: debounced levels, sticky edge capture, masked irq.
// Optional auto-repeat of held buttons when BUTTON_IRQ_AUTOREPEAT_EN is defined.
module button_irq_controller
  import button_irq_pkg::*;
#(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] buttons,
  input  logic [1:0]             avs_address,
  input  logic                   avs_read,
  input  logic                   avs_write,
  input  logic [31:0]            avs_writedata,
  output logic [31:0]            avs_readdata,
  output logic                   irq
);

  localparam int NB = NUM_BUTTONS;

  logic [NB-1:0] stable_v;
  logic [NB-1:0] rise_v;
  logic [NB-1:0] fall_v;
  logic [NB-1:0] event_v;
  logic [NB-1:0] mask_r;
  logic [NB-1:0] edge_r;
  logic [NB-1:0] w1c;
  logic          cfg_both;
  logic          cfg_irq_en;
  logic [31:0]   rd_mux;
  logic          wr_mask;
  logic          wr_cfg;
  logic          unused_wdata;

  for (genvar gi = 0; gi < NB; gi++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk       (clk),
      .reset_n   (reset_n),
      .button    (buttons[gi]),
      .stable    (stable_v[gi]),
      .rise_pulse(rise_v[gi]),
      .fall_pulse(fall_v[gi])
    );
  end

`ifdef BUTTON_IRQ_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);

  logic          cfg_repeat;
  logic [NB-1:0] rep_v;

  // The repeat counter free-runs while held; the CONFIG bit only gates the event.
  for (genvar gi = 0; gi < NB; gi++) begin : g_rep
    logic [RW-1:0] rcnt;
    logic          rep_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rcnt  <= '0;
        rep_q <= 1'b0;
      end else begin
        rep_q <= 1'b0;
        if (!stable_v[gi]) begin
          rcnt <= '0;
        end else if (rcnt == RW'(REPEAT_CYCLES - 1)) begin
          rcnt  <= '0;
          rep_q <= cfg_repeat;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end
    end

    assign rep_v[gi] = rep_q;
  end
`else
  localparam int unused_repeat_cycles = REPEAT_CYCLES;
`endif

  always_comb begin
    event_v = rise_v | (cfg_both ? fall_v : '0);
`ifdef BUTTON_IRQ_AUTOREPEAT_EN
    event_v = event_v | rep_v;
`endif
  end

  assign wr_mask      = avs_write && (avs_address == ADDR_MASK);
  assign wr_cfg       = avs_write && (avs_address == ADDR_CONFIG);
  assign w1c          = (avs_write && (avs_address == ADDR_EDGE)) ? avs_writedata[NB-1:0] : '0;
  assign unused_wdata = ^avs_writedata;

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA:   rd_mux[NB-1:0] = stable_v;
      ADDR_MASK:   rd_mux[NB-1:0] = mask_r;
      ADDR_EDGE:   rd_mux[NB-1:0] = edge_r;
      ADDR_CONFIG: begin
        rd_mux[CFG_BOTH]   = cfg_both;
        rd_mux[CFG_IRQ_EN] = cfg_irq_en;
`ifdef BUTTON_IRQ_AUTOREPEAT_EN
        rd_mux[CFG_REPEAT] = cfg_repeat;
`endif
      end
      default: rd_mux = '0;
    endcase
  end

  // Read data samples pre-write register values; a same-cycle event beats W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
      mask_r       <= '0;
      edge_r       <= '0;
      cfg_both     <= 1'b0;
      cfg_irq_en   <= 1'b0;
`ifdef BUTTON_IRQ_AUTOREPEAT_EN
      cfg_repeat   <= 1'b0;
`endif
      irq          <= 1'b0;
    end else begin
      if (avs_read) avs_readdata <= rd_mux;
      if (wr_mask) mask_r <= avs_writedata[NB-1:0];
      edge_r <= (edge_r & ~w1c) | event_v;
      if (wr_cfg) begin
        cfg_both   <= avs_writedata[CFG_BOTH];
        cfg_irq_en <= avs_writedata[CFG_IRQ_EN];
`ifdef BUTTON_IRQ_AUTOREPEAT_EN
        cfg_repeat <= avs_writedata[CFG_REPEAT];
`endif
      end
      irq <= cfg_irq_en & (|(edge_r & mask_r));
    end
  end

endmodule
